// File: rtl/alu_pipe_pkg.sv
// alu_pkg: shared opcode/flag types for the pipelined ALU and its handshake bundle.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OpSll  = 4'd0,
    OpSrl  = 4'd1,
    OpAdd  = 4'd2,
    OpSub  = 4'd3,
    OpAnd  = 4'd4,
    OpOr   = 4'd5,
    OpXor  = 4'd6,
    OpNor  = 4'd7,
    OpSlt  = 4'd8,
    OpSltu = 4'd9,
    OpSra  = 4'd10,
    OpMul  = 4'd11
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic ovf;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request (in_*) and result (out_*) valid/ready bundle for alu_pipe.
// master = issue/writeback side, slave = the ALU.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  import alu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [ALU_OP_W-1:0] in_op;
  logic [WIDTH-1:0]    in_a;
  logic [WIDTH-1:0]    in_b;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_data;
  logic                out_zero;
  logic                out_neg;
  logic                out_ovf;
  logic                out_illegal;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_neg, out_ovf, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_neg, out_ovf, out_illegal
  );

endinterface

// File: rtl/alu_pipe_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one partial product per cycle for WIDTH cycles.
// Only instantiated when ALU_PIPE_MUL_EN is defined.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_prod
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             r_run;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;

  // Strobe marks the cycle whose edge performs the final iteration.
  assign o_done = r_run && (r_cnt == CW'(WIDTH - 1));
  assign o_prod = r_acc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_run    <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
    end else if (r_run) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (o_done) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage ALU (S1 operand register, S2 result register) with full back-pressure.
// Define ALU_PIPE_MUL_EN to build the iterative multiplier and make MUL a legal op.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic      CLK,
  input  logic      RST,
  alu_pipe_if.slave bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic             r_s1_valid;
  alu_op_t          r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  alu_flags_t       r_out_flags;

  logic             w_s2_adv;
  logic             w_s1_done;
  logic             w_s1_move;
  logic             w_in_ready;
  logic             w_load;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_res;
  alu_flags_t       w_flags;

  assign w_s2_adv   = !r_out_valid || bus.out_ready;
  assign w_s1_move  = r_s1_valid && w_s1_done && w_s2_adv;
  assign w_in_ready = !r_s1_valid || w_s1_move;
  assign w_load     = bus.in_valid && w_in_ready;
  assign w_shamt    = r_s1_b[SHW-1:0];

`ifdef ALU_PIPE_MUL_EN
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       r_mul_st;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_prod;

  assign w_mul_start = w_load && (alu_op_t'(bus.in_op) == OpMul);
  assign w_s1_done   = (r_s1_op != OpMul) || (r_mul_st == StDone);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_start(w_mul_start),
    .i_a    (bus.in_a),
    .i_b    (bus.in_b),
    .o_done (w_mul_done),
    .o_prod (w_mul_prod)
  );

  // A new MUL may load in the same cycle the finished one moves to S2.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mul_st <= StIdle;
    end else if (w_mul_start) begin
      r_mul_st <= StBusy;
    end else begin
      case (r_mul_st)
        StBusy:  if (w_mul_done) r_mul_st <= StDone;
        StDone:  if (w_s1_move) r_mul_st <= StIdle;
        default: r_mul_st <= r_mul_st;
      endcase
    end
  end
`else
  assign w_s1_done = 1'b1;
`endif

  always_comb begin
    w_res   = '0;
    w_flags = '0;
    case (r_s1_op)
      OpSll:  w_res = r_s1_a << w_shamt;
      OpSrl:  w_res = r_s1_a >> w_shamt;
      OpAdd: begin
        w_res       = r_s1_a + r_s1_b;
        w_flags.ovf = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                      (w_res[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      OpSub: begin
        w_res       = r_s1_a - r_s1_b;
        w_flags.ovf = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                      (w_res[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      OpAnd:  w_res = r_s1_a & r_s1_b;
      OpOr:   w_res = r_s1_a | r_s1_b;
      OpXor:  w_res = r_s1_a ^ r_s1_b;
      OpNor:  w_res = ~(r_s1_a | r_s1_b);
      OpSlt:  w_res = {{(WIDTH - 1){1'b0}}, ($signed(r_s1_a) < $signed(r_s1_b))};
      OpSltu: w_res = {{(WIDTH - 1){1'b0}}, (r_s1_a < r_s1_b)};
      OpSra:  w_res = $unsigned($signed(r_s1_a) >>> w_shamt);
`ifdef ALU_PIPE_MUL_EN
      OpMul:  w_res = w_mul_prod;
`endif
      default: w_flags.illegal = 1'b1;
    endcase
    w_flags.zero = (w_res == '0);
    w_flags.neg  = w_res[WIDTH-1];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= OpSll;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_flags <= '0;
    end else begin
      if (w_load) begin
        r_s1_op <= alu_op_t'(bus.in_op);
        r_s1_a  <= bus.in_a;
        r_s1_b  <= bus.in_b;
      end
      if (w_load) begin
        r_s1_valid <= 1'b1;
      end else if (w_s1_move) begin
        r_s1_valid <= 1'b0;
      end
      // S2 only changes on a move, so a stalled result stays put.
      if (w_s1_move) begin
        r_out_data  <= w_res;
        r_out_flags <= w_flags;
      end
      if (w_s1_move) begin
        r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_zero    = r_out_flags.zero;
  assign bus.out_neg     = r_out_flags.neg;
  assign bus.out_ovf     = r_out_flags.ovf;
  assign bus.out_illegal = r_out_flags.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int unsigned W = 32;
`ifdef ALU_PIPE_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic CLK;
  logic RST;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  // {data, zero, neg, ovf, illegal} from the operation definitions.
  function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint          sa, sb, s;
    longint unsigned p;
    logic [W-1:0]    d;
    logic            ovf, ill;
    int              sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b % W);
    d = '0; ovf = 1'b0; ill = 1'b0; s = 0; p = 0;
    case (op)
      4'd0: d = a << sh;
      4'd1: d = a >> sh;
      4'd2, 4'd3: begin
        s   = (op == 4'd2) ? sa + sb : sa - sb;
        d   = s[W-1:0];
        ovf = (s != longint'($signed(d)));
      end
      4'd4: d = a & b;
      4'd5: d = a | b;
      4'd6: d = a ^ b;
      4'd7: d = ~(a | b);
      4'd8: d = (sa < sb) ? W'(1) : '0;
      4'd9: d = (a < b) ? W'(1) : '0;
      4'd10: begin
        s = sa >>> sh;
        d = s[W-1:0];
      end
      4'd11: begin
        if (MulEn) begin
          p = a;
          p = p * b;
          d = p[W-1:0];
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    if (ill) d = '0;
    return {d, (d == '0), d[W-1], ovf, ill};
  endfunction

  function automatic logic [W+3:0] obs();
    return {bus.out_data, bus.out_zero, bus.out_neg, bus.out_ovf, bus.out_illegal};
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(3))
      0: return W'($urandom);
      1: return W'($urandom_range(40));
      2: return 32'h7FFF_FFFF - W'($urandom_range(2));
      default: return 32'h8000_0000 + W'($urandom_range(2));
    endcase
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_a     = '0;
    bus.in_b     = '0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle();
    bus.out_ready = 1'b0;
    repeat (2) cyc();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
    RST = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    else n_pass++;
    n_checks++;
    if (obs() !== '0) $display("FAIL reset_data_flags: got %h expected 0", obs());
    else n_pass++;
    cyc();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_add_ovf();
    bus.out_ready = 1'b1;
    drive(4'd2, 32'h7FFF_FFFF, 32'h1);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL add_accept: got %b expected 1", bus.in_ready);
    else n_pass++;
    cyc();
    idle();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL add_latency_early: got %b expected 0", bus.out_valid);
    else n_pass++;
    cyc();
    n_checks++;
    if ({bus.out_valid, obs()} !== {1'b1, 32'h8000_0000, 4'b0110})
      $display("FAIL add_ovf_result: got %b/%h expected 1/%h", bus.out_valid, obs(),
               {32'h8000_0000, 4'b0110});
    else n_pass++;
    cyc();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL add_drained: got %b expected 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]   ops[3];
    logic [W-1:0] as[3], bs[3], ed[3];
    logic [3:0]   ef[3];
    ops = '{4'd3, 4'd10, 4'd9};
    as  = '{32'h5, 32'h8000_0000, 32'h1};
    bs  = '{32'h5, 32'h4, 32'hFFFF_FFFF};
    ed  = '{32'h0, 32'hF800_0000, 32'h1};
    ef  = '{4'b1000, 4'b0100, 4'b0000};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        drive(ops[k], as[k], bs[k]);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b expected 1", k,
                                            bus.in_ready);
        else n_pass++;
      end else begin
        idle();
      end
      cyc();
      if (k >= 1 && k <= 3) begin
        n_checks++;
        if ({bus.out_valid, obs()} !== {1'b1, ed[k-1], ef[k-1]})
          $display("FAIL b2b_result[%0d]: got %b/%h expected 1/%h", k - 1, bus.out_valid, obs(),
                   {ed[k-1], ef[k-1]});
        else n_pass++;
      end else if (k == 4) begin
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL b2b_tail: got %b expected 0", bus.out_valid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a[3], b[3];
    logic [W+3:0] e[3];
    logic         exp_r;
    int           acc, got, n;
    for (int i = 0; i < 3; i++) begin
      a[i] = W'($urandom);
      b[i] = W'($urandom);
      e[i] = model(4'd2, a[i], b[i]);
    end
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (acc < 3) drive(4'd2, a[acc], b[acc]);
      else idle();
      #1;
      exp_r = (c < 2);
      n_checks++;
      if (bus.in_ready !== exp_r) $display("FAIL bp_in_ready[%0d]: got %b expected %b", c,
                                           bus.in_ready, exp_r);
      else n_pass++;
      if (bus.in_valid && bus.in_ready) acc++;
      cyc();
      if (c >= 1) begin
        n_checks++;
        if ({bus.out_valid, obs()} !== {1'b1, e[0]})
          $display("FAIL bp_hold[%0d]: got %b/%h expected 1/%h", c, bus.out_valid, obs(), e[0]);
        else n_pass++;
      end
    end
    bus.out_ready = 1'b1;
    got = 0;
    n = 0;
    while (got < 3 && n < 12) begin
      if (acc < 3) drive(4'd2, a[acc], b[acc]);
      else idle();
      #1;
      if (bus.in_valid && bus.in_ready) acc++;
      if (bus.out_valid) begin
        n_checks++;
        if (obs() !== e[got]) $display("FAIL bp_order[%0d]: got %h expected %h", got, obs(),
                                       e[got]);
        else n_pass++;
        got++;
      end
      cyc();
      n++;
    end
    idle();
    n_checks++;
    if (got != 3 || acc != 3) $display("FAIL bp_delivered: got %0d results/%0d accepts expected 3/3",
                                       got, acc);
    else n_pass++;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL bp_no_extra: got %b expected 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    drive(4'hF, 32'h1234, 32'h1);
    #1;
    cyc();
    idle();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL illegal_early: got %b expected 0", bus.out_valid);
    else n_pass++;
    cyc();
    n_checks++;
    if ({bus.out_valid, obs()} !== {1'b1, 32'h0, 4'b1001})
      $display("FAIL illegal_result: got %b/%h expected 1/%h", bus.out_valid, obs(),
               {32'h0, 4'b1001});
    else n_pass++;
    cyc();
  endtask

  task automatic test_mul();
    int           n, exp_n;
    logic         exp_r;
    logic [W+3:0] exp_v;
    exp_n = MulEn ? int'(W) + 1 : 1;
    exp_r = !MulEn;
    exp_v = MulEn ? {32'hFFFE_0001, 4'b0100} : {32'h0, 4'b1001};
    bus.out_ready = 1'b1;
    drive(4'd11, 32'hFFFF, 32'hFFFF);
    #1;
    cyc();
    idle();
    n = 0;
    while (!bus.out_valid && n < 100) begin
      if (n < int'(W)) begin
        n_checks++;
        if (bus.in_ready !== exp_r) $display("FAIL mul_in_ready[%0d]: got %b expected %b", n,
                                             bus.in_ready, exp_r);
        else n_pass++;
      end
      cyc();
      n++;
    end
    n_checks++;
    if (n != exp_n) $display("FAIL mul_latency: got %0d cycles expected %0d", n + 1, exp_n + 1);
    else n_pass++;
    n_checks++;
    if (obs() !== exp_v) $display("FAIL mul_result: got %h expected %h", obs(), exp_v);
    else n_pass++;
    cyc();
  endtask

  task automatic test_reset_mid();
    int n, stale;
    bus.out_ready = 1'b0;
    drive(4'd11, W'($urandom), W'($urandom));
    #1;
    cyc();
    idle();
    repeat (5) cyc();
    RST = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
    cyc();
    RST = 1'b0;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10)
      $display("FAIL rst_mid_ready_valid: got %b expected 10", {bus.in_ready, bus.out_valid});
    else n_pass++;
    bus.out_ready = 1'b1;
    drive(4'd2, 32'd2, 32'd3);
    #1;
    cyc();
    idle();
    n = 0;
    while (!bus.out_valid && n < 10) begin
      cyc();
      n++;
    end
    n_checks++;
    if ({bus.out_valid, obs()} !== {1'b1, 32'd5, 4'b0000})
      $display("FAIL rst_mid_add: got %b/%h expected 1/%h", bus.out_valid, obs(),
               {32'd5, 4'b0000});
    else n_pass++;
    stale = 0;
    for (int i = 0; i < int'(W) + 8; i++) begin
      cyc();
      if (bus.out_valid) stale++;
    end
    n_checks++;
    if (stale != 0) $display("FAIL rst_mid_stale: got %0d extra results expected 0", stale);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [W+3:0] q[$];
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         prev_hold;
    int           n;
    prev_hold = 1'b0;
    for (int c = 0; c < 600; c++) begin
      op = 4'($urandom_range(15));
      if (op == 4'd11 && $urandom_range(7) != 0) op = 4'd2;
      a = rnd_operand();
      b = rnd_operand();
      if ($urandom_range(3) != 0) drive(op, a, b);
      else idle();
      bus.out_ready = ($urandom_range(3) != 0);
      #1;
      if (prev_hold) begin
        n_checks++;
        if (bus.out_valid !== 1'b1) $display("FAIL rand_hold_valid[%0d]: got %b expected 1", c,
                                             bus.out_valid);
        else n_pass++;
      end
      if (bus.out_valid) begin
        n_checks++;
        if (q.size() == 0) $display("FAIL rand_spurious[%0d]: got %h expected no result", c, obs());
        else if (obs() !== q[0]) $display("FAIL rand_result[%0d]: got %h expected %h", c, obs(),
                                          q[0]);
        else n_pass++;
        if (bus.out_ready && q.size() != 0) void'(q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(op, a, b));
      prev_hold = bus.out_valid && !bus.out_ready;
      cyc();
    end
    idle();
    bus.out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      #1;
      if (bus.out_valid) begin
        n_checks++;
        if (obs() !== q[0]) $display("FAIL rand_drain_result: got %h expected %h", obs(), q[0]);
        else n_pass++;
        void'(q.pop_front());
      end
      cyc();
      n++;
    end
    n_checks++;
    if (q.size() != 0 || bus.out_valid !== 1'b0)
      $display("FAIL rand_drain: got %0d pending/valid %b expected 0/0", q.size(), bus.out_valid);
    else n_pass++;
  endtask

  initial begin
    RST = 1'b1;
    idle();
    bus.out_ready = 1'b0;
    test_reset();
    test_add_ovf();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_mul();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the single-cycle combinational ALU. Accepts operations over a valid/ready handshake, registers operands, computes result and status flags, and holds the result in an output register until the consumer takes it. It sits between issue logic and writeback in the block-level datapath and supports full back-pressure. An optional iterative multiplier adds a multi-cycle operation.

## Interface
- WIDTH, 32, operand/result width; legal values 8..64, power of two.
- SHW, $clog2(WIDTH), derived shift-amount width; not to be overridden.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_op  input  4  operation code, alu_op_t.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  result.
- out_zero  output  1  out_data == 0.
- out_neg  output  1  out_data[WIDTH-1].
- out_ovf  output  1  signed overflow; ADD/SUB only, otherwise 0.
- out_illegal  output  1  op unsupported in this build.

## Operation
- Ops: SLL=0, SRL=1, ADD=2, SUB=3, AND=4, OR=5, XOR=6, NOR=7, SLT=8, SLTU=9, SRA=10, MUL=11. Codes 12..15 are illegal.
- Shifts use in_b[SHW-1:0]. SLT and SLTU produce a result of 0 or 1, zero-extended.
- ADD/SUB wrap modulo 2^WIDTH.
  - ADD ovf = operands share a sign and the result sign differs.
  - SUB ovf = operands' signs differ and the result sign differs from A.
- Illegal op: out_data=0, out_zero=1, out_illegal=1, other flags 0. The op still occupies a pipeline slot.
- Stage S1 holds the operand register (s1_valid). Stage S2 holds the result register (out_valid).
- Request transfer: in_valid && in_ready. Result transfer: out_valid && out_ready.
- S2 advances when !out_valid || out_ready.
- in_ready = !s1_valid || (S1 op complete && S2 advances). It is combinational from out_ready.
- While out_valid && !out_ready, out_data and all flags are held stable.
- Results leave in strict request order. No request is dropped or duplicated.

## Timing
- Reset values: in_ready=1 (after RST deasserts), out_valid=0, out_data=0, all flags 0, s1_valid=0, MUL FSM=IDLE.
- Single-cycle op latency: request accepted at edge N gives out_valid=1 after edge N+1.
- Throughput is 1 op/cycle with out_ready held high.
- Simultaneous events: in the same cycle, S2 unloads, S1 moves to S2 and a new request loads S1.
- MUL FSM: IDLE -> BUSY on a MUL load into S1. BUSY iterates shift-add for WIDTH cycles using a counter, then -> DONE. DONE -> IDLE when S1 moves to S2.
- in_ready=0 while the FSM is BUSY, and while it is DONE with S2 blocked.
- MUL result is the low WIDTH bits of the product. Latency is WIDTH+2 cycles from acceptance to out_valid.
- RST asserted mid-operation clears every stage and the FSM immediately. The in-flight op is discarded.

## Configuration
- ALU_PIPE_MUL_EN defined: the iterative multiplier and its FSM are compiled in, and MUL is legal.
- ALU_PIPE_MUL_EN undefined: no multiplier logic. MUL behaves as an illegal op with 2-cycle latency.

## Structure
- Package alu_pkg holds:
  - alu_op_t enum (4-bit),
  - alu_flags_t struct {zero, neg, ovf, illegal},
  - localparam ALU_OP_W=4.
- Sub-module alu_mul_iter (parametrised by WIDTH) contains the shift-add multiplier, its cycle counter and start/done strobes.
- It is instantiated only under ALU_PIPE_MUL_EN.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF+0x1 -> out_data 0x80000000, ovf=1, neg=1, zero=0, out_valid two cycles after acceptance.
- SUB 0x5-0x5, then SRA 0x80000000 by 4, then SLTU 0x1 vs 0xFFFFFFFF back-to-back with out_ready=1 -> results in order:
  - 0x0 with zero=1,
  - 0xF8000000,
  - 0x1;
  - one result per cycle.
- Back-pressure: issue 3 ADDs, hold out_ready=0 for 4 cycles -> in_ready drops after 2 accepts, out_data is held unchanged, all 3 results delivered in order after release.
- in_op=0xF, A=0x1234, B=0x1 -> out_data 0, zero=1, illegal=1.
- With ALU_PIPE_MUL_EN: MUL 0xFFFF*0xFFFF -> 0xFFFE0001 after 34 cycles, in_ready=0 during BUSY. Without the macro: the same op gives illegal=1 after 2 cycles.
- Assert RST during a MUL in BUSY -> next cycle out_valid=0, in_ready=1 after release, and the following ADD 2+3 returns 5 with no stale result.
